// File: rtl/perceptron_train_sequencer_if.sv
// Control-side bundle between the training sequencer and its host/core/memories.
// The host drives start/abort; the sequencer drives everything else.
interface perceptron_train_sequencer_if #(
  parameter int unsigned ADDR_W = 10
);
  logic              start;
  logic              abort;
  logic              core_rst;
  logic [3:0]        control;
  logic [ADDR_W-1:0] x1_cnt;
  logic [ADDR_W-1:0] x2_cnt;
  logic [ADDR_W-1:0] label_cnt;
  logic [7:0]        epoch;
  logic              busy;
  logic              done;

  modport master (
    output start, abort,
    input  core_rst, control, x1_cnt, x2_cnt, label_cnt, epoch, busy, done
  );

  modport slave (
    input  start, abort,
    output core_rst, control, x1_cnt, x2_cnt, label_cnt, epoch, busy, done
  );
endinterface

// File: rtl/perceptron_train_sequencer.sv
// Perceptron training sequencer: per sample GAP -> core reset -> run, walking
// all samples for EPOCHS passes, then a single done pulse.
module perceptron_train_sequencer #(
  parameter int unsigned ADDR_W          = 10,
  parameter int unsigned NUM_SAMPLES     = 500,
  parameter int unsigned EPOCHS          = 1,
  parameter int unsigned CORE_RST_CYCLES = 5,
  parameter int unsigned RUN_CYCLES      = 80
) (
  input  logic                          clk,
  input  logic                          rst,
  perceptron_train_sequencer_if.slave   bus
);

  localparam int unsigned CNT_MAX = (CORE_RST_CYCLES > RUN_CYCLES) ? CORE_RST_CYCLES : RUN_CYCLES;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_GAP  = 2'd1;
  localparam logic [1:0] S_RST  = 2'd2;
  localparam logic [1:0] S_RUN  = 2'd3;

  localparam logic [ADDR_W-1:0] LAST_IDX   = ADDR_W'(NUM_SAMPLES - 1);
  localparam logic [7:0]        LAST_EPOCH = 8'(EPOCHS - 1);

  logic [1:0]        state, state_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic [ADDR_W-1:0] idx, idx_nx;
  logic [7:0]        ep, ep_nx;
  logic              core_rst_q, core_rst_nx;
  logic [3:0]        control_q, control_nx;
  logic              busy_q, busy_nx;
  logic              done_q, done_nx;

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      idx        <= '0;
      ep         <= '0;
      core_rst_q <= 1'b0;
      control_q  <= 4'b0000;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      idx        <= idx_nx;
      ep         <= ep_nx;
      core_rst_q <= core_rst_nx;
      control_q  <= control_nx;
      busy_q     <= busy_nx;
      done_q     <= done_nx;
    end
  end

  // Next state; the dwell counter is reloaded on every state entry.
  always_comb begin
    state_nx = state;
    cnt_nx   = (cnt == '0) ? '0 : cnt - CNT_W'(1);
    idx_nx   = idx;
    ep_nx    = ep;
    done_nx  = 1'b0;

    case (state)
      S_IDLE: begin
        if (bus.start && !bus.abort) begin
          state_nx = S_GAP;
          cnt_nx   = '0;
          idx_nx   = '0;
          ep_nx    = '0;
        end
      end
      S_GAP: begin
        state_nx = S_RST;
        cnt_nx   = CNT_W'(CORE_RST_CYCLES - 1);
      end
      S_RST: begin
        if (cnt == '0) begin
          state_nx = S_RUN;
          cnt_nx   = CNT_W'(RUN_CYCLES - 1);
        end
      end
      S_RUN: begin
        if (cnt == '0) begin
          cnt_nx = '0;
          if (idx < LAST_IDX) begin
            state_nx = S_GAP;
            idx_nx   = idx + ADDR_W'(1);
          end else if (ep < LAST_EPOCH) begin
            state_nx = S_GAP;
            idx_nx   = '0;
            ep_nx    = ep + 8'd1;
          end else begin
            state_nx = S_IDLE;
            done_nx  = 1'b1;
          end
        end
      end
      default: state_nx = S_IDLE;
    endcase

    // Abort overrides any transition, including the final done.
    if (bus.abort && (state != S_IDLE)) begin
      state_nx = S_IDLE;
      cnt_nx   = '0;
      idx_nx   = '0;
      ep_nx    = '0;
      done_nx  = 1'b0;
    end

    core_rst_nx = (state_nx == S_RST);
    control_nx  = (state_nx == S_RUN) ? 4'b1111 : 4'b0000;
    busy_nx     = (state_nx != S_IDLE);
  end

  assign bus.core_rst  = core_rst_q;
  assign bus.control   = control_q;
  assign bus.x1_cnt    = idx;
  assign bus.x2_cnt    = idx;
  assign bus.label_cnt = idx;
  assign bus.epoch     = ep;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_perceptron_train_sequencer.sv
// Directed bench for perceptron_train_sequencer: N=3, EPOCHS=2, 5 reset + 8 run cycles (P=14).
module tb_perceptron_train_sequencer;

  localparam int unsigned ADDR_W = 10;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  perceptron_train_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

  perceptron_train_sequencer #(
    .ADDR_W(ADDR_W), .NUM_SAMPLES(3), .EPOCHS(2), .CORE_RST_CYCLES(5), .RUN_CYCLES(8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observation vector: {core_rst, control, index, epoch, busy, done}
  function automatic logic [24:0] obs_vec();
    return {bus.core_rst, bus.control, bus.x1_cnt, bus.epoch, bus.busy, bus.done};
  endfunction

  // Expected vector c cycles after the start edge of a nominal run.
  function automatic logic [24:0] exp_at(int c);
    int s, ph;
    logic [9:0] ix;
    logic [7:0] e;
    if (c >= 1 && c <= 84) begin
      s  = (c - 1) / 14;
      ph = (c - 1) % 14;
      ix = 10'(s % 3);
      e  = 8'(s / 3);
      return {(ph >= 1 && ph <= 5), (ph >= 6) ? 4'b1111 : 4'b0000, ix, e, 1'b1, 1'b0};
    end else if (c == 85) begin
      return {1'b0, 4'b0000, 10'd2, 8'd1, 1'b0, 1'b1};
    end
    return {1'b0, 4'b0000, 10'd2, 8'd1, 1'b0, 1'b0};
  endfunction

  task automatic chk(input string tag, input logic [24:0] obs, input logic [24:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idx(input string tag, input logic [9:0] expi);
    chk({tag, "_x2"}, 25'(bus.x2_cnt), 25'(expi));
    chk({tag, "_lbl"}, 25'(bus.label_cnt), 25'(expi));
  endtask

  initial begin
    logic [24:0] ev;
    n_checks  = 0;
    n_fail    = 0;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    rst       = 1'b1;
    #2 rst    = 1'b0;

    // Reset held 3 cycles, then released
    repeat (3) tick();
    chk("reset_hold", obs_vec(), 25'd0);
    chk_idx("reset_hold", 10'd0);
    @(negedge clk) rst = 1'b1;
    tick();
    chk("reset_release", obs_vec(), 25'd0);

    // Nominal walk, with a stray start during RST of sample 1
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int c = 1; c <= 86; c++) begin
      ev = exp_at(c);
      chk($sformatf("walk_c%0d", c), obs_vec(), ev);
      chk_idx($sformatf("walk_c%0d", c), ev[19:10]);
      bus.start = (c == 16);
      tick();
    end
    bus.start = 1'b0;

    // Abort mid-RUN at index 1, epoch 0
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int c = 1; c <= 22; c++) begin
      chk($sformatf("pre_abort_c%0d", c), obs_vec(), exp_at(c));
      if (c < 22) tick();
    end
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("abort_next", obs_vec(), 25'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("abort_idle", obs_vec(), 25'd0);
    end

    // Abort and start together in IDLE: stays IDLE
    bus.abort = 1'b1;
    bus.start = 1'b1;
    tick();
    bus.abort = 1'b0;
    bus.start = 1'b0;
    chk("abort_start_idle", obs_vec(), 25'd0);
    tick();
    chk("abort_start_idle2", obs_vec(), 25'd0);

    // Restart from index 0, then async reset during RST of sample 1
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      chk($sformatf("restart_c%0d", c), obs_vec(), exp_at(c));
      if (c < 16) tick();
    end
    #2 rst = 1'b0;
    #1;
    chk("async_rst", obs_vec(), 25'd0);
    @(negedge clk) rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("post_rst_idle", obs_vec(), 25'd0);
    end

    // Abort on the final RUN cycle suppresses done
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int c = 1; c <= 84; c++) begin
      chk($sformatf("final_c%0d", c), obs_vec(), exp_at(c));
      if (c < 84) tick();
    end
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("abort_final", obs_vec(), 25'd0);
    tick();
    chk("abort_final2", obs_vec(), 25'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
